counter_modn_chain: RTL and testbench
=====================================

# counter_modn_chain

Parametrised cascaded modulo-N up/down counter, the general-purpose successor to the single-digit MOD10 timer digit. It chains `DIGITS` 4-bit digits, each with its own modulus, so one instance implements a complete MM:SS cook-time counter (default configuration) or any other mixed-radix counter. It adds direction control, clamped loading, an optional hold-at-zero mode and a registered completion pulse. It sits between the keypad/time-entry logic and the display/magnetron control in the microwave controller.

## Interface
- `DIGITS`, 4: number of cascaded digits; legal range 1..8.
- `MOD_VEC`, 16'hAA6A: per-digit modulus, 4 bits per digit, digit 0 in bits [3:0]. Each field must be 2..15. The default is MM:SS: digit0 mod 10, digit1 mod 6, digit2 mod 10, digit3 mod 10.
- `HOLD_AT_ZERO`, 1: 1 = down-counting stops at all-zero; 0 = wraps.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `clear` in 1: asynchronous, active-low reset; forces the count to 0 and `done` to 0.
- `load` in 1: synchronous, active-low parallel load.
- `enab` in 1: count enable; active high.
- `down` in 1: direction; 1 = decrement, 0 = increment.
- `numero` in 4*DIGITS: load value, same digit packing as `MOD_VEC`.
- `numero_saida` out 4*DIGITS: registered count.
- `tc_saida` out 1: terminal count; combinational.
- `zero_saida` out 1: high when all digits are 0; combinational.
- `done` out 1: registered one-cycle completion pulse.

## Operation
- Priority at each edge: `clear` (async) > `load` > `enab` > hold.
- Load: each digit d receives min(`numero`[d], MOD[d]-1). Out-of-range fields clamp to MOD-1. A load never asserts `done`.
- Down count, when `enab`=1 and `down`=1:
  - Digit 0 always steps.
  - Digit d>0 steps only when every lower digit is 0.
  - A stepping digit goes from v to v-1, or from 0 to MOD[d]-1.
- Up count, when `enab`=1 and `down`=0:
  - Digit 0 always steps.
  - Digit d>0 steps only when every lower digit is MOD-1.
  - A stepping digit goes from v to v+1, or from MOD[d]-1 to 0.
- Hold-at-zero: if `HOLD_AT_ZERO`=1, `down`=1 and the count is all-zero, an enabled edge leaves the count unchanged. There is no wrap. Up-counting from zero is unaffected.
- `zero_saida` = (all digits == 0).
- `tc_saida`:
  - Down mode: `enab` & `zero_saida`.
  - Up mode: `enab` & (all digits == MOD-1).
  - Holds regardless of `HOLD_AT_ZERO`.
- `done`: set for exactly one cycle after an enabled down-count edge that changes the count from non-zero to all-zero. It is 0 on every other cycle, including:
  - edges held at zero;
  - loads of zero;
  - wraps in up mode.
- Direction may change on any cycle. It takes effect at the next edge with no extra state.

## Timing
- Reset values: `numero_saida`=0 and `done`=0, immediately on `clear` falling, independent of `clk`. Consequently `zero_saida`=1, and `tc_saida` = `enab` & `down`.
- `clear` release: the first active edge is the first rising `clk` with `clear`=1.
- Load latency: 1 edge. The value is visible on `numero_saida` after the edge where `load`=0.
- Count latency: 1 edge per step. The cascade carry is combinational within the same edge, so all digits update simultaneously. There is no ripple delay across cycles.
- `tc_saida` and `zero_saida` follow `numero_saida`, `enab` and `down` combinationally, in the same cycle.
- `done`: asserted in the cycle following the edge that reaches zero, i.e. coincident with `numero_saida`=0. It deasserts at the next edge.
- Simultaneous `load`=0 and `enab`=1: load wins and no count step occurs.
- `clear` asserted mid-pulse: `done` drops immediately.

## Test plan
Default parameters (MM:SS) unless stated.
- Reset mid-count:
  - Stimulus: count at 0x0123, assert `clear`=0 between edges.
  - Required: `numero_saida`=0x0000 and `zero_saida`=1 before the next edge; `done`=0.
- Load and down cascade:
  - Stimulus: load 0x0100, then `enab`=1, `down`=1.
  - Required: successive edges give 0x0059 and 0x0058.
  - Stimulus: load 0x1000.
  - Required: next edge gives 0x0959.
- Completion with hold:
  - Stimulus: load 0x0001, `enab`=1, `down`=1.
  - Required: edge 1 gives 0x0000 with `done`=1 for one cycle. Later edges stay at 0x0000 with `done`=0 and `tc_saida`=1.
- Wrap mode:
  - Stimulus: `HOLD_AT_ZERO`=0, count 0x0000, down, enabled.
  - Required: next edge gives 0x9959; `done` stays 0.
- Up count:
  - Stimulus: 0x0059 with `down`=0.
  - Required: 0x0100.
  - Stimulus: 0x9959 with `enab`=1.
  - Required: `tc_saida`=1; next edge gives 0x0000; `done`=0.
- Clamp and priority:
  - Stimulus: load 0x00F7 with `enab`=1 simultaneously.
  - Required: 0x0057 after the edge, with no decrement. Loading 0x0000 gives `done`=0.

Source files
------------

// File: rtl/counter_modn_chain.sv
// Cascaded mixed-radix up/down counter: DIGITS 4-bit digits, each with its own modulus,
// clamped parallel load, optional hold-at-zero and a registered completion pulse.
module counter_modn_chain #(
  parameter int          DIGITS       = 4,
  parameter logic [31:0] MOD_VEC      = 32'h0000_AA6A,
  parameter bit          HOLD_AT_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  enab,
  input  logic                  down,
  input  logic [4*DIGITS-1:0]   numero,
  output logic [4*DIGITS-1:0]   numero_saida,
  output logic                  tc_saida,
  output logic                  zero_saida,
  output logic                  done
);

  logic [4*DIGITS-1:0] count_reg;
  logic [4*DIGITS-1:0] count_next;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] step_val;
  logic                done_reg;
  logic                done_next;

  // chain_zero[d] / chain_max[d]: every digit below d is 0 / at its top value.
  logic [DIGITS:0] chain_zero;
  logic [DIGITS:0] chain_max;

  assign chain_zero[0] = 1'b1;
  assign chain_max[0]  = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      localparam logic [3:0] DIGIT_MOD = MOD_VEC[4*gi +: 4];
      localparam logic [3:0] DIGIT_TOP = DIGIT_MOD - 4'd1;

      logic [3:0] cur;
      logic [3:0] inc_val;
      logic [3:0] dec_val;
      logic [3:0] in_val;
      logic       is_zero;
      logic       is_top;

      assign cur     = count_reg[4*gi +: 4];
      assign in_val  = numero[4*gi +: 4];
      assign is_zero = (cur == 4'd0);
      assign is_top  = (cur == DIGIT_TOP);

      assign chain_zero[gi+1] = chain_zero[gi] & is_zero;
      assign chain_max[gi+1]  = chain_max[gi] & is_top;

      assign inc_val = is_top  ? 4'd0      : cur + 4'd1;
      assign dec_val = is_zero ? DIGIT_TOP : cur - 4'd1;

      assign load_val[4*gi +: 4] = (in_val > DIGIT_TOP) ? DIGIT_TOP : in_val;
      assign step_val[4*gi +: 4] = down ? (chain_zero[gi] ? dec_val : cur)
                                        : (chain_max[gi]  ? inc_val : cur);
    end
  endgenerate

  assign zero_saida = chain_zero[DIGITS];
  assign tc_saida   = enab & (down ? chain_zero[DIGITS] : chain_max[DIGITS]);

  logic hold_zero;
  assign hold_zero = HOLD_AT_ZERO && down && chain_zero[DIGITS];

  always_comb begin
    count_next = count_reg;
    done_next  = 1'b0;
    if (!load) begin
      count_next = load_val;
    end else if (enab && !hold_zero) begin
      count_next = step_val;
      // Completion only on a real transition from non-zero into all-zero while counting down.
      done_next  = down && !chain_zero[DIGITS] && (step_val == '0);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  assign numero_saida = count_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_counter_modn_chain.sv
// Directed bench for counter_modn_chain in the default MM:SS configuration, with a second
// instance built without hold-at-zero to exercise the down-count wrap.
module tb_counter_modn_chain;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        load = 1'b1;
  logic        enab = 1'b0;
  logic        down = 1'b0;
  logic [15:0] numero = 16'h0000;

  logic [15:0] numero_saida;
  logic        tc_saida;
  logic        zero_saida;
  logic        done;

  logic [15:0] numero_saida_w;
  logic        tc_saida_w;
  logic        zero_saida_w;
  logic        done_w;

  int vectors = 0;
  int errors  = 0;

  counter_modn_chain #(
    .DIGITS(4), .MOD_VEC(32'h0000_AA6A), .HOLD_AT_ZERO(1'b1)
  ) dut (
    .clk(clk), .clear(clear), .load(load), .enab(enab), .down(down), .numero(numero),
    .numero_saida(numero_saida), .tc_saida(tc_saida), .zero_saida(zero_saida), .done(done)
  );

  counter_modn_chain #(
    .DIGITS(4), .MOD_VEC(32'h0000_AA6A), .HOLD_AT_ZERO(1'b0)
  ) dut_wrap (
    .clk(clk), .clear(clear), .load(load), .enab(enab), .down(down), .numero(numero),
    .numero_saida(numero_saida_w), .tc_saida(tc_saida_w), .zero_saida(zero_saida_w),
    .done(done_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
  endtask

  // One active edge, then settle to the falling edge where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] val);
    load   = 1'b0;
    numero = val;
    tick();
    load   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Asynchronous reset, no clock edge needed
    #1 clear = 1'b0;
    #1;
    chk("rst_count", numero_saida, 16'h0000);
    chk("rst_zero",  {15'd0, zero_saida}, 16'd1);
    chk("rst_done",  {15'd0, done}, 16'd0);
    chk("rst_tc_idle", {15'd0, tc_saida}, 16'd0);
    enab = 1'b1; down = 1'b1;
    #1;
    chk("rst_tc_down", {15'd0, tc_saida}, 16'd1);
    @(negedge clk);
    clear = 1'b1; enab = 1'b0; down = 1'b0;

    // Reset mid-count
    do_load(16'h0123);
    chk("load_0123", numero_saida, 16'h0123);
    enab = 1'b1;
    tick();
    chk("up_0124", numero_saida, 16'h0124);
    #2 clear = 1'b0;
    #1;
    chk("midrst_count", numero_saida, 16'h0000);
    chk("midrst_zero",  {15'd0, zero_saida}, 16'd1);
    chk("midrst_done",  {15'd0, done}, 16'd0);
    @(negedge clk);
    clear = 1'b1; enab = 1'b0;

    // Down cascade across minutes boundary
    do_load(16'h0100);
    chk("load_0100", numero_saida, 16'h0100);
    enab = 1'b1; down = 1'b1;
    tick();
    chk("dn_0059", numero_saida, 16'h0059);
    chk("dn_0059_done", {15'd0, done}, 16'd0);
    tick();
    chk("dn_0058", numero_saida, 16'h0058);
    enab = 1'b0;
    do_load(16'h1000);
    chk("load_1000", numero_saida, 16'h1000);
    enab = 1'b1;
    tick();
    chk("dn_0959", numero_saida, 16'h0959);
    enab = 1'b0;

    // Completion, hold at zero, and wrap on the second instance
    do_load(16'h0001);
    enab = 1'b1; down = 1'b1;
    tick();
    chk("cmp_count", numero_saida, 16'h0000);
    chk("cmp_done",  {15'd0, done}, 16'd1);
    chk("cmp_tc",    {15'd0, tc_saida}, 16'd1);
    chk("cmp_done_w", {15'd0, done_w}, 16'd1);
    tick();
    chk("hold_count", numero_saida, 16'h0000);
    chk("hold_done",  {15'd0, done}, 16'd0);
    chk("hold_tc",    {15'd0, tc_saida}, 16'd1);
    chk("wrap_count", numero_saida_w, 16'h9959);
    chk("wrap_done",  {15'd0, done_w}, 16'd0);
    tick();
    chk("hold2_count", numero_saida, 16'h0000);
    chk("hold2_done",  {15'd0, done}, 16'd0);
    chk("wrap2_count", numero_saida_w, 16'h9958);
    enab = 1'b0;

    // Clear in the middle of a done pulse drops it at once
    do_load(16'h0001);
    enab = 1'b1;
    tick();
    chk("pulse_done", {15'd0, done}, 16'd1);
    #1 clear = 1'b0;
    #1;
    chk("pulse_clr_done", {15'd0, done}, 16'd0);
    @(negedge clk);
    clear = 1'b1; enab = 1'b0;

    // Up count
    do_load(16'h0059);
    enab = 1'b1; down = 1'b0;
    tick();
    chk("up_0100", numero_saida, 16'h0100);
    enab = 1'b0;
    do_load(16'h9959);
    #1;
    chk("max_tc_dis", {15'd0, tc_saida}, 16'd0);
    enab = 1'b1; down = 1'b1;
    #1;
    chk("max_tc_down", {15'd0, tc_saida}, 16'd0);
    down = 1'b0;
    #1;
    chk("max_tc_up", {15'd0, tc_saida}, 16'd1);
    tick();
    chk("upwrap_count", numero_saida, 16'h0000);
    chk("upwrap_done",  {15'd0, done}, 16'd0);
    tick();
    chk("up_0001", numero_saida, 16'h0001);
    enab = 1'b0;

    // Clamp and load-over-count priority
    enab = 1'b1; down = 1'b1;
    do_load(16'h00F7);
    chk("clamp_0057", numero_saida, 16'h0057);
    enab = 1'b0;
    do_load(16'hFFFF);
    chk("clamp_9959", numero_saida, 16'h9959);
    do_load(16'h0000);
    chk("load0_count", numero_saida, 16'h0000);
    chk("load0_done",  {15'd0, done}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
